// File: rtl/ethernet_rx_framer.sv
// MII nibble receive framer: strips preamble/SFD, packs bytes and buffers whole frames in a
// FIFO that only exposes committed, length-valid frames; rejected frames are rolled back and counted.
module ethernet_rx_framer #(
  parameter int ADDR_WIDTH   = 11,
  parameter int MIN_FRAME    = 64,
  parameter int MAX_FRAME    = 1518,
  parameter int PREAMBLE_MIN = 8,
  parameter int COUNT_WIDTH  = 16
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   enable,
  input  logic                   rx_dv,
  input  logic                   nibble_valid,
  input  logic [3:0]             nibble,
  input  logic                   rd,
  output logic [7:0]             r_data,
  output logic                   r_last,
  output logic                   empty,
  output logic                   full,
  output logic [COUNT_WIDTH-1:0] frame_count,
  output logic [COUNT_WIDTH-1:0] drop_count
);

  localparam int DEPTH = 1 << ADDR_WIDTH;
  localparam int PW    = ADDR_WIDTH + 1;
  localparam int LW    = $clog2(MAX_FRAME + 2);
  localparam int PCW   = $clog2(PREAMBLE_MIN + 1);

  localparam logic [PW-1:0]  DEPTH_P = PW'(DEPTH);
  localparam logic [LW-1:0]  MIN_L   = LW'(MIN_FRAME);
  localparam logic [LW-1:0]  MAX_L   = LW'(MAX_FRAME);
  localparam logic [PCW-1:0] PMIN_P  = PCW'(PREAMBLE_MIN);

  typedef enum logic [1:0] {
    S_IDLE     = 2'd0,
    S_PREAMBLE = 2'd1,
    S_DATA     = 2'd2,
    S_DROP     = 2'd3
  } state_t;

  state_t                 r_state;
  logic [8:0]             r_mem [DEPTH];
  logic [PW-1:0]          r_rd_ptr;
  logic [PW-1:0]          r_wr_ptr;
  logic [PW-1:0]          r_commit_ptr;
  logic [PCW-1:0]         r_pcnt;
  logic [LW-1:0]          r_len;
  logic                   r_half;
  logic [3:0]             r_lo;
  logic [7:0]             r_stage;
  logic                   r_stage_vld;
  logic [COUNT_WIDTH-1:0] r_frame_count;
  logic [COUNT_WIDTH-1:0] r_drop_count;

  logic       w_rd_fire;
  logic       w_byte_done;
  logic       w_end;
  logic       w_len_ok;
  logic       w_overflow;
  logic       w_too_long;
  logic       w_stage_wr;
  logic       w_commit;
  logic       w_mem_we;
  logic [8:0] w_head;

  assign empty       = (r_rd_ptr == r_commit_ptr);
  assign full        = ((r_wr_ptr - r_rd_ptr) == DEPTH_P);
  assign w_head      = r_mem[r_rd_ptr[ADDR_WIDTH-1:0]];
  assign r_data      = empty ? 8'h00 : w_head[7:0];
  assign r_last      = empty ? 1'b0 : w_head[8];
  assign frame_count = r_frame_count;
  assign drop_count  = r_drop_count;

  assign w_rd_fire   = rd && !empty;
  assign w_byte_done = (r_state == S_DATA) && enable && rx_dv && nibble_valid && r_half;
  assign w_end       = (r_state == S_DATA) && enable && !rx_dv;
  assign w_len_ok    = (r_len >= MIN_L) && (r_len <= MAX_L);
  // The newest byte lives in the stage register so it can be tagged last=1 once the frame ends.
  assign w_overflow  = w_byte_done && r_stage_vld && full;
  assign w_too_long  = w_byte_done && !w_overflow && (r_len == MAX_L);
  assign w_stage_wr  = w_byte_done && r_stage_vld && !full;
  assign w_commit    = w_end && w_len_ok && r_stage_vld && !full;
  assign w_mem_we    = w_stage_wr || w_commit;

  always_ff @(posedge clk) begin
    if (w_mem_we) begin
      r_mem[r_wr_ptr[ADDR_WIDTH-1:0]] <= {w_commit, r_stage};
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state       <= S_IDLE;
      r_rd_ptr      <= '0;
      r_wr_ptr      <= '0;
      r_commit_ptr  <= '0;
      r_pcnt        <= '0;
      r_len         <= '0;
      r_half        <= 1'b0;
      r_lo          <= 4'h0;
      r_stage       <= 8'h00;
      r_stage_vld   <= 1'b0;
      r_frame_count <= '0;
      r_drop_count  <= '0;
    end else begin
      if (w_rd_fire) begin
        r_rd_ptr <= r_rd_ptr + 1'b1;
      end
      if (!enable) begin
        if (r_state == S_DATA) begin
          r_wr_ptr     <= r_commit_ptr;
          r_drop_count <= r_drop_count + 1'b1;
        end
        r_state <= S_IDLE;
      end else begin
        case (r_state)
          S_IDLE: begin
            if (nibble_valid && rx_dv && (nibble == 4'h5)) begin
              r_state <= S_PREAMBLE;
              r_pcnt  <= PCW'(1);
            end
          end
          S_PREAMBLE: begin
            if (!rx_dv) begin
              r_state <= S_IDLE;
            end else if (nibble_valid) begin
              if (nibble == 4'h5) begin
                if (r_pcnt != '1) r_pcnt <= r_pcnt + 1'b1;
              end else if ((nibble == 4'hD) && (r_pcnt >= PMIN_P)) begin
                r_state     <= S_DATA;
                r_len       <= '0;
                r_half      <= 1'b0;
                r_stage_vld <= 1'b0;
              end else begin
                r_state <= S_DROP;
              end
            end
          end
          S_DATA: begin
            if (!rx_dv) begin
              // A trailing odd nibble is simply forgotten here.
              if (w_commit) begin
                r_wr_ptr      <= r_wr_ptr + 1'b1;
                r_commit_ptr  <= r_wr_ptr + 1'b1;
                r_frame_count <= r_frame_count + 1'b1;
              end else begin
                r_wr_ptr     <= r_commit_ptr;
                r_drop_count <= r_drop_count + 1'b1;
              end
              r_state <= S_IDLE;
            end else if (nibble_valid) begin
              if (!r_half) begin
                r_lo   <= nibble;
                r_half <= 1'b1;
              end else begin
                r_half <= 1'b0;
                if (w_overflow || w_too_long) begin
                  r_wr_ptr     <= r_commit_ptr;
                  r_drop_count <= r_drop_count + 1'b1;
                  r_state      <= S_DROP;
                end else begin
                  if (w_stage_wr) r_wr_ptr <= r_wr_ptr + 1'b1;
                  r_stage     <= {nibble, r_lo};
                  r_stage_vld <= 1'b1;
                  if (r_len != '1) r_len <= r_len + 1'b1;
                end
              end
            end
          end
          S_DROP: begin
            if (!rx_dv) r_state <= S_IDLE;
          end
          default: r_state <= S_IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_ethernet_rx_framer.sv
// Randomised bench for ethernet_rx_framer: frames are judged by a frame-level reference model
// (preamble/SFD rule, length window, free FIFO space) and read back byte by byte.
module tb_ethernet_rx_framer;

  localparam int AW    = 11;
  localparam int DEPTH = 2048;
  localparam int MINF  = 64;
  localparam int MAXF  = 1518;
  localparam int PMIN  = 8;
  localparam int CW    = 16;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          enable = 1'b0;
  logic          rx_dv = 1'b0;
  logic          nibble_valid = 1'b0;
  logic [3:0]    nibble = 4'h0;
  logic          rd = 1'b0;
  logic [7:0]    r_data;
  logic          r_last;
  logic          empty;
  logic          full;
  logic [CW-1:0] frame_count;
  logic [CW-1:0] drop_count;

  ethernet_rx_framer #(
    .ADDR_WIDTH(AW), .MIN_FRAME(MINF), .MAX_FRAME(MAXF),
    .PREAMBLE_MIN(PMIN), .COUNT_WIDTH(CW)
  ) dut (
    .clk(clk), .reset(rst_n), .enable(enable), .rx_dv(rx_dv),
    .nibble_valid(nibble_valid), .nibble(nibble), .rd(rd),
    .r_data(r_data), .r_last(r_last), .empty(empty), .full(full),
    .frame_count(frame_count), .drop_count(drop_count)
  );

  always #5 clk = ~clk;

  int         n_checks = 0;
  int         n_fail = 0;
  int         exp_frames = 0;
  int         exp_drops = 0;
  logic [8:0] model_q[$];
  logic [7:0] tx_bytes [0:2047];

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  task automatic fill_bytes(input bit counting, input int n);
    for (int i = 0; i < n; i++) tx_bytes[i] = counting ? 8'(i) : 8'($urandom);
  endtask

  task automatic put_nib(input logic [3:0] n);
    nibble = n; nibble_valid = 1'b1; rx_dv = 1'b1;
    @(negedge clk);
    nibble_valid = 1'b0;
    repeat ($urandom_range(0, 1)) @(negedge clk);
  endtask

  task automatic send_partial(input int npre, input bit good_sfd, input int nbytes, input bit odd_nib);
    logic [3:0] sfd;
    sfd = good_sfd ? 4'hD : 4'h7;
    for (int i = 0; i < npre; i++) put_nib(4'h5);
    put_nib(sfd);
    for (int i = 0; i < nbytes; i++) begin
      put_nib(tx_bytes[i][3:0]);
      put_nib(tx_bytes[i][7:4]);
    end
    if (odd_nib) put_nib(4'hA);
  endtask

  // Frame-level outcome: a frame is kept only if its preamble/SFD is acceptable, its byte
  // count lies in the legal window and the FIFO has room for every byte of it.
  task automatic send_frame(input int npre, input bit good_sfd, input int nbytes, input bit odd_nib);
    int free_space;
    send_partial(npre, good_sfd, nbytes, odd_nib);
    rx_dv = 1'b0;
    @(negedge clk);
    if (npre >= PMIN && good_sfd) begin
      free_space = DEPTH - model_q.size();
      if (nbytes < MINF || nbytes > MAXF || nbytes > free_space) begin
        exp_drops++;
      end else begin
        for (int i = 0; i < nbytes; i++) model_q.push_back({(i == nbytes - 1), tx_bytes[i]});
        exp_frames++;
      end
    end
  endtask

  task automatic check_status(input string tag);
    check({tag, "_frames"}, 32'(frame_count), 32'(exp_frames[CW-1:0]));
    check({tag, "_drops"}, 32'(drop_count), 32'(exp_drops[CW-1:0]));
    check({tag, "_empty"}, 32'(empty), 32'(model_q.size() == 0));
  endtask

  task automatic pop_all(input string tag);
    while (model_q.size() > 0) begin
      check({tag, "_byte"}, {23'd0, empty, r_last, r_data}, {23'd0, 1'b0, model_q[0]});
      rd = 1'b1;
      @(negedge clk);
      void'(model_q.pop_front());
    end
    rd = 1'b0;
    check({tag, "_drained"}, 32'(empty), 32'd1);
  endtask

  task automatic stream_reader(input int target);
    int got = 0;
    int cyc = 0;
    while (got < target && cyc < 6000) begin
      if (!empty && model_q.size() > 0) begin
        check("stream_byte", {23'd0, r_last, r_data}, {23'd0, model_q[0]});
        rd = 1'b1;
        got++;
      end else begin
        rd = 1'b0;
      end
      @(negedge clk);
      if (rd) void'(model_q.pop_front());
      cyc++;
    end
    rd = 1'b0;
    check("stream_count", 32'(got), 32'(target));
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int kind, len, npre;
    repeat (3) @(negedge clk);
    check("rst_empty", 32'(empty), 32'd1);
    check("rst_full", 32'(full), 32'd0);
    check("rst_counts", {frame_count, drop_count}, 32'd0);
    check("rst_out", {23'd0, r_last, r_data}, 32'd0);
    rst_n = 1'b1; enable = 1'b1;
    @(negedge clk);

    // Long preamble, minimum-length frame of a counting pattern.
    fill_bytes(1'b1, 64);
    send_frame(15, 1'b1, 64, 1'b0);
    check_status("t1");
    pop_all("t1");

    // Short frames are dropped, including one byte under the minimum.
    fill_bytes(1'b0, 32);
    send_frame(8, 1'b1, 32, 1'b0);
    check_status("t2a");
    fill_bytes(1'b0, 63);
    send_frame(8, 1'b1, 63, 1'b0);
    check_status("t2b");

    // Fill the FIFO exactly with unread frames, then overflow it.
    for (int f = 0; f < DEPTH / 64; f++) begin
      fill_bytes(1'b0, 64);
      send_frame(8, 1'b1, 64, 1'b0);
    end
    check("t3_full", 32'(full), 32'd1);
    fill_bytes(1'b0, 64);
    send_frame(8, 1'b1, 64, 1'b0);
    check_status("t3");
    pop_all("t3");
    check("t3_notfull", 32'(full), 32'd0);

    // Preamble too short, then an oversize frame, then the maximum legal size.
    fill_bytes(1'b0, 80);
    send_frame(3, 1'b1, 80, 1'b0);
    check_status("t4a");
    fill_bytes(1'b0, 1600);
    send_frame(8, 1'b1, 1600, 1'b0);
    check_status("t4b");
    fill_bytes(1'b0, MAXF);
    send_frame(9, 1'b1, MAXF, 1'b0);
    check_status("t4c");
    pop_all("t4c");

    // Odd trailing nibble, then reading continuously while the next frame arrives.
    fill_bytes(1'b0, 100);
    send_frame(10, 1'b1, 100, 1'b1);
    check_status("t5a");
    fill_bytes(1'b0, 80);
    fork
      send_frame(9, 1'b1, 80, 1'b0);
      stream_reader(180);
    join
    check_status("t5b");

    // Reset in the middle of a frame with a committed frame still buffered.
    fill_bytes(1'b0, 70);
    send_frame(8, 1'b1, 70, 1'b0);
    check_status("t6a");
    send_partial(8, 1'b1, 10, 1'b0);
    rst_n = 1'b0;
    #1;
    check("t6_rst_empty", 32'(empty), 32'd1);
    check("t6_rst_full", 32'(full), 32'd0);
    check("t6_rst_counts", {frame_count, drop_count}, 32'd0);
    check("t6_rst_out", {23'd0, r_last, r_data}, 32'd0);
    rx_dv = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    model_q.delete();
    exp_frames = 0;
    exp_drops = 0;
    @(negedge clk);

    // Enable dropped mid-frame: rollback and one drop, then a clean frame.
    fill_bytes(1'b0, 20);
    send_partial(8, 1'b1, 20, 1'b0);
    enable = 1'b0;
    @(negedge clk);
    enable = 1'b1; rx_dv = 1'b0;
    @(negedge clk);
    exp_drops++;
    check_status("t6b");
    fill_bytes(1'b0, 70);
    send_frame(8, 1'b1, 70, 1'b0);
    check_status("t6c");
    pop_all("t6c");

    // Random mix of frame kinds with occasional reads so the FIFO can also overflow.
    for (int k = 0; k < 20; k++) begin
      kind = $urandom_range(0, 5);
      npre = $urandom_range(PMIN, 15);
      len  = $urandom_range(MINF, 160);
      if (kind == 2) len = $urandom_range(1, MINF - 1);
      if (kind == 4) npre = $urandom_range(1, PMIN - 1);
      fill_bytes(1'b0, len);
      send_frame(npre, kind != 5, len, kind == 3);
      check_status("rnd");
      if ($urandom_range(0, 2) == 0) pop_all("rnd");
    end
    pop_all("final");

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
